// File: rtl/dmux_router_pkg.sv
// Shared types and constants for the 1-to-2 packet demultiplexer.
package dmux_router_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FWD  = 1'b1
  } state_t;

  localparam logic MODE_DEST = 1'b0;
  localparam logic MODE_RR   = 1'b1;

  // Output chosen for the first beat of a packet.
  function automatic logic pick_route(input logic mode, input logic dest, input logic rr);
    return (mode == MODE_RR) ? rr : dest;
  endfunction

endpackage

// File: rtl/dmux_router_dmux2_path.sv
// Combinational 1-to-2 steering of valid/data/last; the unselected side drives zeros.
module dmux2_path #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              sel,
  input  logic              valid,
  input  logic [DATA_W-1:0] data,
  input  logic              last,
  output logic              out0_valid,
  output logic [DATA_W-1:0] out0_data,
  output logic              out0_last,
  output logic              out1_valid,
  output logic [DATA_W-1:0] out1_data,
  output logic              out1_last
);

  always_comb begin
    out0_valid = 1'b0;
    out0_data  = '0;
    out0_last  = 1'b0;
    out1_valid = 1'b0;
    out1_data  = '0;
    out1_last  = 1'b0;
    if (valid) begin
      if (sel) begin
        out1_valid = 1'b1;
        out1_data  = data;
        out1_last  = last;
      end else begin
        out0_valid = 1'b1;
        out0_data  = data;
        out0_last  = last;
      end
    end
  end

endmodule

// File: rtl/dmux_router.sv
// Packet router: one input stream steered to two outputs through a single holding register.
module dmux_router
  import dmux_router_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              in_dest,
  output logic              out0_valid,
  input  logic              out0_ready,
  output logic [DATA_W-1:0] out0_data,
  output logic              out0_last,
  output logic              out1_valid,
  input  logic              out1_ready,
  output logic [DATA_W-1:0] out1_data,
  output logic              out1_last,
  output logic [CNT_W-1:0]  pkt_cnt0,
  output logic [CNT_W-1:0]  pkt_cnt1,
  output logic              busy
);

  state_t            state;
  logic              route_sel;
  logic              route_rr;
  logic              rr_ptr;

  logic              hold_vld;
  logic [DATA_W-1:0] hold_data;
  logic              hold_last;
  logic              hold_sel;

  logic              first_beat;
  logic              beat_sel;
  logic              beat_rr;
  logic              sel_ready;
  logic              can_take;
  logic              accept;
  logic              drain;

  // Routing for the incoming beat: decided on the first beat, locked for the rest.
  always_comb begin
    first_beat = (state == IDLE);
    beat_sel   = first_beat ? pick_route(mode, in_dest, rr_ptr) : route_sel;
    beat_rr    = first_beat ? (mode == MODE_RR) : route_rr;
    sel_ready  = hold_sel ? out1_ready : out0_ready;
    drain      = hold_vld && sel_ready;
    can_take   = !hold_vld || sel_ready;
    accept     = in_valid && can_take;
  end

  assign in_ready = can_take;
  assign busy     = (state == FWD) || hold_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      route_sel <= 1'b0;
      route_rr  <= 1'b0;
      rr_ptr    <= 1'b0;
    end else if (accept) begin
      case (state)
        IDLE: begin
          if (!in_last) begin
            state     <= FWD;
            route_sel <= beat_sel;
            route_rr  <= beat_rr;
          end
        end
        FWD: begin
          if (in_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // Round-robin advances per completed packet, using the mode latched at its first beat.
      if (in_last && beat_rr) rr_ptr <= ~rr_ptr;
    end
  end

  // Accept wins over drain so a simultaneous drain+accept replaces the beat without a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_vld  <= 1'b0;
      hold_data <= '0;
      hold_last <= 1'b0;
      hold_sel  <= 1'b0;
    end else if (accept) begin
      hold_vld  <= 1'b1;
      hold_data <= in_data;
      hold_last <= in_last;
      hold_sel  <= beat_sel;
    end else if (drain) begin
      hold_vld  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
    end else if (drain && hold_last) begin
      if (hold_sel) pkt_cnt1 <= pkt_cnt1 + CNT_W'(1);
      else          pkt_cnt0 <= pkt_cnt0 + CNT_W'(1);
    end
  end

  dmux2_path #(
    .DATA_W(DATA_W)
  ) u_path (
    .sel        (hold_sel),
    .valid      (hold_vld),
    .data       (hold_data),
    .last       (hold_last),
    .out0_valid (out0_valid),
    .out0_data  (out0_data),
    .out0_last  (out0_last),
    .out1_valid (out1_valid),
    .out1_data  (out1_data),
    .out1_last  (out1_last)
  );

endmodule

// File: tb/tb_dmux_router.sv
// Directed self-checking bench for dmux_router; a second CNT_W=2 instance checks counter wrap.
module tb_dmux_router;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       mode = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_last = 1'b0;
  logic       in_dest = 1'b0;
  logic       out0_ready = 1'b1;
  logic       out1_ready = 1'b1;

  logic       in_ready, out0_valid, out0_last, out1_valid, out1_last, busy;
  logic [7:0] out0_data, out1_data, pkt_cnt0, pkt_cnt1;

  logic       w_in_ready, w_out0_valid, w_out0_last, w_out1_valid, w_out1_last, w_busy;
  logic [7:0] w_out0_data, w_out1_data;
  logic [1:0] w_pkt_cnt0, w_pkt_cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmux_router #(.DATA_W(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_dest(in_dest),
    .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data), .out0_last(out0_last),
    .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data), .out1_last(out1_last),
    .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .busy(busy)
  );

  dmux_router #(.DATA_W(8), .CNT_W(2)) dut_w2 (
    .clk(clk), .rst(rst), .mode(mode),
    .in_valid(in_valid), .in_ready(w_in_ready), .in_data(in_data),
    .in_last(in_last), .in_dest(in_dest),
    .out0_valid(w_out0_valid), .out0_ready(out0_ready), .out0_data(w_out0_data), .out0_last(w_out0_last),
    .out1_valid(w_out1_valid), .out1_ready(out1_ready), .out1_data(w_out1_data), .out1_last(w_out1_last),
    .pkt_cnt0(w_pkt_cnt0), .pkt_cnt1(w_pkt_cnt1), .busy(w_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    out0_ready = 1'b1; out1_ready = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out0_valid !== 1'b0) begin errors++; $display("FAIL reset_out0_valid got %b want 0", out0_valid); end
    checks++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL reset_out1_valid got %b want 0", out1_valid); end
    checks++; if (out0_data !== 8'h00 || out1_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h/%h want 00/00", out0_data, out1_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (pkt_cnt0 !== 8'd0 || pkt_cnt1 !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d/%0d want 0/0", pkt_cnt0, pkt_cnt1); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_dest();
    logic [7:0] beats [3] = '{8'h11, 8'h22, 8'h33};
    do_reset();
    mode = 1'b0; in_dest = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = beats[i]; in_last = (i == 2);
      tick();
      checks++; if (out1_valid !== 1'b1 || out1_data !== beats[i] || out1_last !== (i == 2))
        begin errors++; $display("FAIL dest_beat%0d got v=%b d=%h l=%b want v=1 d=%h l=%b", i, out1_valid, out1_data, out1_last, beats[i], (i == 2)); end
      checks++; if (out0_valid !== 1'b0) begin errors++; $display("FAIL dest_out0_quiet%0d got %b want 0", i, out0_valid); end
    end
    in_valid = 1'b0; in_last = 1'b0;
    tick();
    checks++; if (pkt_cnt1 !== 8'd1 || pkt_cnt0 !== 8'd0) begin errors++; $display("FAIL dest_cnt got %0d/%0d want 0/1", pkt_cnt0, pkt_cnt1); end
    checks++; if (busy !== 1'b0 || out1_valid !== 1'b0) begin errors++; $display("FAIL dest_idle got busy=%b v1=%b want 0/0", busy, out1_valid); end
  endtask

  task automatic test_rr();
    do_reset();
    mode = 1'b1; in_dest = 1'b1; in_valid = 1'b1; in_last = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'hA0 + 8'(i);
      tick();
      if (i % 2 == 0) begin
        checks++; if (out0_valid !== 1'b1 || out1_valid !== 1'b0 || out0_data !== 8'hA0 + 8'(i))
          begin errors++; $display("FAIL rr_pkt%0d got v0=%b v1=%b d0=%h want v0=1 v1=0 d0=%h", i, out0_valid, out1_valid, out0_data, 8'hA0 + 8'(i)); end
      end else begin
        checks++; if (out1_valid !== 1'b1 || out0_valid !== 1'b0 || out1_data !== 8'hA0 + 8'(i))
          begin errors++; $display("FAIL rr_pkt%0d got v0=%b v1=%b d1=%h want v0=0 v1=1 d1=%h", i, out0_valid, out1_valid, out1_data, 8'hA0 + 8'(i)); end
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    tick();
    checks++; if (pkt_cnt0 !== 8'd2 || pkt_cnt1 !== 8'd2) begin errors++; $display("FAIL rr_cnt got %0d/%0d want 2/2", pkt_cnt0, pkt_cnt1); end
  endtask

  task automatic test_sticky();
    do_reset();
    mode = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_dest = 1'(i % 2); in_data = 8'h50 + 8'(i); in_last = (i == 3);
      tick();
      checks++; if (out0_valid !== 1'b1 || out1_valid !== 1'b0 || out0_data !== 8'h50 + 8'(i))
        begin errors++; $display("FAIL sticky_beat%0d got v0=%b v1=%b d0=%h want v0=1 v1=0 d0=%h", i, out0_valid, out1_valid, out0_data, 8'h50 + 8'(i)); end
    end
    in_valid = 1'b0; in_last = 1'b0; in_dest = 1'b0;
    tick();
    checks++; if (pkt_cnt0 !== 8'd1 || pkt_cnt1 !== 8'd0) begin errors++; $display("FAIL sticky_cnt got %0d/%0d want 1/0", pkt_cnt0, pkt_cnt1); end
  endtask

  task automatic test_stall();
    do_reset();
    mode = 1'b0; in_dest = 1'b0; in_valid = 1'b1; in_last = 1'b0;
    in_data = 8'hC0;
    tick();
    out0_ready = 1'b0; in_data = 8'hC1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got %b want 0", in_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out0_valid !== 1'b1 || out0_data !== 8'hC0 || in_ready !== 1'b0)
        begin errors++; $display("FAIL stall_hold%0d got v=%b d=%h rdy=%b want v=1 d=c0 rdy=0", i, out0_valid, out0_data, in_ready); end
    end
    out0_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      in_data = 8'hC0 + 8'(i); in_last = (i == 3);
      tick();
      checks++; if (out0_valid !== 1'b1 || out0_data !== 8'hC0 + 8'(i))
        begin errors++; $display("FAIL stall_release%0d got v=%b d=%h want v=1 d=%h", i, out0_valid, out0_data, 8'hC0 + 8'(i)); end
    end
    in_valid = 1'b0; in_last = 1'b0;
    tick();
    checks++; if (pkt_cnt0 !== 8'd1 || out0_valid !== 1'b0) begin errors++; $display("FAIL stall_end got cnt=%0d v=%b want 1/0", pkt_cnt0, out0_valid); end
  endtask

  task automatic test_wrap();
    logic [1:0] exp_w [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    do_reset();
    mode = 1'b0; in_dest = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_last = 1'b1; in_data = 8'(i);
      tick();
      in_valid = 1'b0; in_last = 1'b0;
      tick();
      checks++; if (w_pkt_cnt0 !== exp_w[i]) begin errors++; $display("FAIL wrap_cnt%0d got %0d want %0d", i, w_pkt_cnt0, exp_w[i]); end
      checks++; if (pkt_cnt0 !== 8'(i + 1)) begin errors++; $display("FAIL wide_cnt%0d got %0d want %0d", i, pkt_cnt0, i + 1); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    mode = 1'b1; in_valid = 1'b1; in_last = 1'b1; in_data = 8'hE0;
    tick();
    out1_ready = 1'b0; in_last = 1'b0; in_data = 8'hE1;
    tick();
    in_valid = 1'b0;
    checks++; if (out1_valid !== 1'b1 || busy !== 1'b1 || pkt_cnt0 !== 8'd1)
      begin errors++; $display("FAIL midpkt_pre got v1=%b busy=%b cnt0=%0d want 1/1/1", out1_valid, busy, pkt_cnt0); end
    rst = 1'b1;
    tick();
    rst = 1'b0; out1_ready = 1'b1;
    checks++; if (out0_valid !== 1'b0 || out1_valid !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL midpkt_clear got v0=%b v1=%b busy=%b want 0/0/0", out0_valid, out1_valid, busy); end
    checks++; if (pkt_cnt0 !== 8'd0 || pkt_cnt1 !== 8'd0) begin errors++; $display("FAIL midpkt_cnt got %0d/%0d want 0/0", pkt_cnt0, pkt_cnt1); end
    in_valid = 1'b1; in_last = 1'b1; in_data = 8'hE2;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    checks++; if (out0_valid !== 1'b1 || out1_valid !== 1'b0 || out0_data !== 8'hE2)
      begin errors++; $display("FAIL midpkt_rr got v0=%b v1=%b d0=%h want 1/0/e2", out0_valid, out1_valid, out0_data); end
  endtask

  initial begin
    test_reset();
    test_dest();
    test_rr();
    test_sticky();
    test_stall();
    test_wrap();
    test_reset_mid();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmux_router.md
DMUX_ROUTER -- requirements
Module: dmux_router

Interface
REQ-001 Parameter DATA_W, default 8, beat payload width in bits.
REQ-002 Parameter CNT_W, default 8, width of each per-output packet counter.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port mode  input  1  routing policy: 0 = by in_dest, 1 = round-robin per packet.
REQ-006 Port in_valid  input  1  input beat valid.
REQ-007 Port in_ready  output  1  input beat accepted when in_valid and in_ready are both 1.
REQ-008 Port in_data  input  DATA_W  input payload.
REQ-009 Port in_last  input  1  marks the final beat of a packet.
REQ-010 Port in_dest  input  1  destination output (0 or 1), used in mode 0.
REQ-011 Ports out0_valid/out1_valid  output  1 each  output beat valid.
REQ-012 Ports out0_ready/out1_ready  input  1 each  downstream ready.
REQ-013 Ports out0_data/out1_data  output  DATA_W each  output payload.
REQ-014 Ports out0_last/out1_last  output  1 each  output end-of-packet.
REQ-015 Ports pkt_cnt0/pkt_cnt1  output  CNT_W each  completed packets per output.
REQ-016 Port busy  output  1  1 while a packet is open or the holding register is full.

Function
REQ-017 FSM states: IDLE (no packet open) and FWD (packet open, routing locked).
REQ-018 IDLE: on an accepted beat with in_last=0, the FSM SHALL latch route_sel and go to FWD; with in_last=1 it SHALL stay in IDLE.
REQ-019 FWD: on an accepted beat with in_last=1, the FSM SHALL return to IDLE; otherwise it SHALL stay in FWD.
REQ-020 route_sel on the first beat: mode 0 -> in_dest; mode 1 -> rr_ptr; mode and in_dest SHALL be ignored on non-first beats.
REQ-021 rr_ptr SHALL toggle only when a mode-1 packet's last beat is accepted; a mode change mid-packet takes effect at the next first beat.
REQ-022 A single holding register (hold_vld, data, last, sel) SHALL carry each beat; latency from acceptance to output valid is exactly 1 cycle.
REQ-023 in_ready = !hold_vld OR ready of the output selected by hold sel (full-throughput pass-through, no combinational in_valid->in_ready path).
REQ-024 outN_valid = hold_vld AND (hold sel == N); the unselected output SHALL drive valid=0, data=0, last=0.
REQ-025 Holding register SHALL hold stable while its output valid is 1 and ready is 0.
REQ-026 pkt_cntN SHALL increment by 1 when a beat with last=1 transfers on output N, wrapping modulo 2^CNT_W.
REQ-027 Simultaneous drain and accept in one cycle SHALL replace the holding register with the new beat, with no bubble and no loss.
REQ-028 busy = (state == FWD) OR hold_vld.

Reset
REQ-029 With rst=1 at a clock edge: state=IDLE, hold_vld=0, rr_ptr=0, pkt_cnt0=pkt_cnt1=0; all outputs valid=0, data=0, last=0, busy=0.
REQ-030 Reset mid-packet SHALL discard the held beat and open packet; no counter increments in that cycle.

Structure
REQ-031 Shared package dmux_router_pkg SHALL hold the state enum (IDLE, FWD) and the mode constants MODE_DEST=0, MODE_RR=1.
REQ-032 The output steering SHALL be one combinational sub-module, dmux2_path (1-to-2 demux of valid/data/last on sel), instantiated once.

Verification
REQ-033 Mode 0, 3-beat packet 0x11,0x22,0x33 with in_dest=1, outputs always ready -> beats on out1 at cycles N+1..N+3; out0_valid stays 0; pkt_cnt1=1.
REQ-034 Mode 1, four 1-beat packets -> alternate out0, out1, out0, out1; pkt_cnt0=2, pkt_cnt1=2.
REQ-035 Mode 0, in_dest toggled every beat within a 4-beat packet to 0 -> all 4 beats on out0.
REQ-036 out0_ready held 0 for 3 cycles mid-packet -> out0_data stable, in_ready=0, no beat lost or duplicated after release.
REQ-037 CNT_W=2, five 1-beat packets to out0 -> pkt_cnt0 sequence 1,2,3,0,1.
REQ-038 rst=1 asserted during FWD with hold_vld=1 -> next cycle all valids 0, busy=0, counters 0; next packet routed per REQ-020 with rr_ptr=0.
